reduce_sequencer: RTL and testbench

- Sequences the calculator datapath for one operator reduction: pop operator, pop B, pop A, drive ALU, push result.
- Sits between the main controller and the data stack, operator stack and ALU, so the controller issues one start instead of hand-stepping each reduction.
- Supports a single-step mode and a drain mode. Drain mode repeats reductions until the operator stack is empty, and is used at end of expression.

---
 rtl/reduce_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_reduce_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_sequencer.sv
// -----------------------------------------------------------------------------
// reduce_sequencer
//
// Steps the calculator datapath through one operator reduction:
//   pop operator -> pop B (top) -> pop A -> drive ALU -> push result (A op B).
// In drain mode the reductions repeat until the operator stack is empty.
//
// Optional feature (compile-time macro REDUCE_DIV0_CHECK_EN):
//   when defined, a divide (op == DIV_OP) with B == 0 ends the run in ERR
//   after A has been popped, and nothing is pushed.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start, drain  run request (sampled in IDLE) and drain-mode select
//   busy          high in every non-IDLE state
//   done, err     one-cycle completion pulse; err is valid with done and held
//   count         reductions completed in the current/last run (saturating)
//   result        last ALU result pushed
//   dt_*          data stack: top/empty in, pop/push strobes and write data out
//   op_*          operator stack: top/empty in, pop strobe out
//   al_A/B/cmd/C  ALU operands and command out, result in
// -----------------------------------------------------------------------------
module reduce_sequencer #(
    parameter int DW     = 32,
    parameter int OW     = 4,
    parameter int DIV_OP = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          drain,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    count,
    output logic [DW-1:0] result,
    input  logic [DW-1:0] dt_top,
    input  logic          dt_empty,
    output logic          dt_pop,
    output logic          dt_push,
    output logic [DW-1:0] dt_wdata,
    input  logic [OW-1:0] op_top,
    input  logic          op_empty,
    output logic          op_pop,
    output logic [DW-1:0] al_A,
    output logic [DW-1:0] al_B,
    output logic [OW-1:0] al_cmd,
    input  logic [DW-1:0] al_C
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_OP = 3'd1,
        POP_B  = 3'd2,
        POP_A  = 3'd3,
        EXEC   = 3'd4,
        PUSH   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t          state_r;
    logic            drain_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic [7:0]      count_r;
    logic [DW-1:0]   result_r;
    logic [DW-1:0]   a_r;
    logic [DW-1:0]   b_r;
    logic [OW-1:0]   op_r;
    logic            op_pop_r;
    logic            dt_pop_r;
    logic            dt_push_r;

    // Saturating reduction counter increment.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Sequencer FSM: state plus every registered output and operand latch.
    // Strobe registers are loaded on entry to the state that owns them, so
    // they are high exactly for that state's cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            drain_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            count_r   <= 8'd0;
            result_r  <= '0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            op_pop_r  <= 1'b0;
            dt_pop_r  <= 1'b0;
            dt_push_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            op_pop_r  <= 1'b0;
            dt_pop_r  <= 1'b0;
            dt_push_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        drain_r  <= drain;
                        count_r  <= 8'd0;
                        err_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        op_pop_r <= 1'b1;
                        state_r  <= POP_OP;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                POP_OP: begin
                    if (op_empty) begin
                        // Empty op stack is normal completion only when draining.
                        done_r  <= 1'b1;
                        err_r   <= ~drain_r;
                        state_r <= drain_r ? DONE : ERR;
                    end else begin
                        op_r     <= op_top;
                        dt_pop_r <= 1'b1;
                        state_r  <= POP_B;
                    end
                end
                POP_B: begin
                    if (dt_empty) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        b_r      <= dt_top;
                        dt_pop_r <= 1'b1;
                        state_r  <= POP_A;
                    end
                end
                POP_A: begin
                    if (dt_empty) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        a_r <= dt_top;
`ifdef REDUCE_DIV0_CHECK_EN
                        // A is consumed either way; a zero divisor aborts before EXEC.
                        if ((op_r == DIV_OP[OW-1:0]) && (b_r == '0)) begin
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                            state_r <= ERR;
                        end else begin
                            state_r <= EXEC;
                        end
`else
                        state_r <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    result_r  <= al_C;
                    dt_push_r <= 1'b1;
                    state_r   <= PUSH;
                end
                PUSH: begin
                    count_r <= sat_inc(count_r);
                    if (drain_r) begin
                        op_pop_r <= 1'b1;
                        state_r  <= POP_OP;
                    end else begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b0;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                ERR: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Pops are qualified by the live empty flags so an empty stack is never
    // popped on the cycle the FSM takes its error/exit branch.
    assign op_pop   = op_pop_r & ~op_empty;
    assign dt_pop   = dt_pop_r & ~dt_empty;
    assign dt_push  = dt_push_r;
    assign dt_wdata = result_r;

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign count  = count_r;
    assign result = result_r;

    assign al_A   = a_r;
    assign al_B   = b_r;
    assign al_cmd = op_r;

endmodule

// File: tb/tb_reduce_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for reduce_sequencer: behavioural data/operator stacks and ALU
// around the sequencer, a table of directed reductions with hand-computed
// results, plus hand-written saturation and mid-run reset sequences.
// -----------------------------------------------------------------------------
module tb_reduce_sequencer;

    localparam int DW    = 32;
    localparam int OW    = 4;
    localparam int DEPTH = 512;

    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] MUL = 4'd3;
    localparam logic [3:0] DIV = 4'd4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          drain;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    count;
    logic [DW-1:0] result;
    logic [DW-1:0] dt_top;
    logic          dt_empty;
    logic          dt_pop;
    logic          dt_push;
    logic [DW-1:0] dt_wdata;
    logic [OW-1:0] op_top;
    logic          op_empty;
    logic          op_pop;
    logic [DW-1:0] al_A;
    logic [DW-1:0] al_B;
    logic [OW-1:0] al_cmd;
    logic [DW-1:0] al_C;

    reduce_sequencer #(.DW(DW), .OW(OW), .DIV_OP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .drain(drain),
        .busy(busy), .done(done), .err(err), .count(count), .result(result),
        .dt_top(dt_top), .dt_empty(dt_empty), .dt_pop(dt_pop),
        .dt_push(dt_push), .dt_wdata(dt_wdata),
        .op_top(op_top), .op_empty(op_empty), .op_pop(op_pop),
        .al_A(al_A), .al_B(al_B), .al_cmd(al_cmd), .al_C(al_C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack models (index 0 = bottom) with a bench-side load port.
    logic [DW-1:0] dmem [DEPTH];
    logic [OW-1:0] omem [DEPTH];
    int            dsp;
    int            osp;
    logic          ld;
    logic [DW-1:0] ld_dmem [DEPTH];
    logic [OW-1:0] ld_omem [DEPTH];
    int            ld_dsp;
    int            ld_osp;

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < DEPTH; i++) begin
                dmem[i] <= ld_dmem[i];
                omem[i] <= ld_omem[i];
            end
            dsp <= ld_dsp;
            osp <= ld_osp;
        end else begin
            if (dt_pop && dsp > 0) begin
                dsp <= dsp - 1;
            end else if (dt_push) begin
                dmem[dsp] <= dt_wdata;
                dsp       <= dsp + 1;
            end
            if (op_pop && osp > 0) begin
                osp <= osp - 1;
            end
        end
    end

    assign dt_empty = (dsp == 0);
    assign op_empty = (osp == 0);
    assign dt_top   = (dsp > 0) ? dmem[dsp-1] : 32'd0;
    assign op_top   = (osp > 0) ? omem[osp-1] : 4'd0;

    // ALU model; divide by zero yields all ones.
    always_comb begin
        case (al_cmd)
            ADD:     al_C = al_A + al_B;
            SUB:     al_C = al_A - al_B;
            MUL:     al_C = al_A * al_B;
            DIV:     al_C = (al_B == 32'd0) ? 32'hFFFF_FFFF : al_A / al_B;
            default: al_C = 32'd0;
        endcase
    end

    int n_cmp;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        drn;
        logic [7:0]  nd;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [7:0]  no;
        logic [3:0]  o0;
        logic [3:0]  o1;
        logic [15:0] cyc;
        logic        err;
        logic [7:0]  cnt;
        logic [31:0] res;
        logic [7:0]  dsp;
        logic [31:0] top;
        logic [7:0]  osp;
    } vec_t;

    // Start a run, return the cycle (edge 0 = acceptance) in which done is high.
    task automatic run(input logic drn, input int budget, output int dcyc, output logic derr);
        @(negedge clk);
        start = 1'b1;
        drain = drn;
        @(posedge clk);
        dcyc = -1;
        derr = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            // start stays high a few cycles: it must be ignored while busy
            if (c == 3) start = 1'b0;
            chk("busy_in_run", {31'd0, busy}, 32'd1);
            chk("strobe_onehot", {31'd0, ($countones({dt_pop, dt_push, op_pop}) <= 1)}, 32'd1);
            if (done) begin
                dcyc = c;
                derr = err;
                break;
            end
        end
        start = 1'b0;
        if (dcyc < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            chk("done_pulse", {31'd0, done}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("err_held", {31'd0, err}, {31'd0, derr});
        end
    endtask

    task automatic do_vec(input string nm, input vec_t v);
        int   dcyc;
        logic derr;
        @(negedge clk);
        ld_dmem[0] = v.d0;
        ld_dmem[1] = v.d1;
        ld_dmem[2] = v.d2;
        ld_omem[0] = v.o0;
        ld_omem[1] = v.o1;
        ld_dsp     = int'(v.nd);
        ld_osp     = int'(v.no);
        ld         = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        run(v.drn, 100, dcyc, derr);
        chk({nm, "_cycle"}, dcyc, {16'd0, v.cyc});
        chk({nm, "_err"}, {31'd0, derr}, {31'd0, v.err});
        chk({nm, "_count"}, {24'd0, count}, {24'd0, v.cnt});
        chk({nm, "_result"}, result, v.res);
        chk({nm, "_dsp"}, dsp, {24'd0, v.dsp});
        chk({nm, "_osp"}, osp, {24'd0, v.osp});
        if (v.dsp != 8'd0) chk({nm, "_dtop"}, dt_top, v.top);
    endtask

    vec_t tbl [10];
    int   dcyc;
    logic derr;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        start  = 1'b0;
        drain  = 1'b0;
        ld     = 1'b0;
        ld_dsp = 0;
        ld_osp = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_dmem[i] = 32'd0;
            ld_omem[i] = 4'd0;
        end
        rst = 1'b1;

        //         drn  nd    d0          d1      d2     no    o0   o1   cyc     err   cnt   res               dsp   top               osp
        tbl[0] = '{1'b0, 8'd2, 32'd7,  32'd3,  32'd0, 8'd1, SUB, 4'd0, 16'd6,  1'b0, 8'd1, 32'd4,           8'd1, 32'd4,           8'd0};
        tbl[1] = '{1'b1, 8'd3, 32'd2,  32'd3,  32'd4, 8'd2, ADD, MUL,  16'd12, 1'b0, 8'd2, 32'd14,          8'd1, 32'd14,          8'd0};
        tbl[2] = '{1'b0, 8'd1, 32'd5,  32'd0,  32'd0, 8'd1, ADD, 4'd0, 16'd4,  1'b1, 8'd0, 32'd14,          8'd0, 32'd0,           8'd0};
        tbl[3] = '{1'b1, 8'd1, 32'd8,  32'd0,  32'd0, 8'd0, 4'd0, 4'd0, 16'd2, 1'b0, 8'd0, 32'd14,          8'd1, 32'd8,           8'd0};
        tbl[4] = '{1'b0, 8'd1, 32'd8,  32'd0,  32'd0, 8'd0, 4'd0, 4'd0, 16'd2, 1'b1, 8'd0, 32'd14,          8'd1, 32'd8,           8'd0};
        tbl[5] = '{1'b0, 8'd2, 32'd10, 32'd20, 32'd0, 8'd1, ADD, 4'd0, 16'd6,  1'b0, 8'd1, 32'd30,          8'd1, 32'd30,          8'd0};
        tbl[6] = '{1'b0, 8'd2, 32'd6,  32'd7,  32'd0, 8'd2, SUB, MUL,  16'd6,  1'b0, 8'd1, 32'd42,          8'd1, 32'd42,          8'd1};
        tbl[7] = '{1'b1, 8'd2, 32'd1,  32'd2,  32'd0, 8'd2, ADD, ADD,  16'd9,  1'b1, 8'd1, 32'd3,           8'd0, 32'd0,           8'd0};
        tbl[8] = '{1'b0, 8'd2, 32'd20, 32'd4,  32'd0, 8'd1, DIV, 4'd0, 16'd6,  1'b0, 8'd1, 32'd5,           8'd1, 32'd5,           8'd0};
`ifdef REDUCE_DIV0_CHECK_EN
        tbl[9] = '{1'b0, 8'd2, 32'd9,  32'd0,  32'd0, 8'd1, DIV, 4'd0, 16'd4,  1'b1, 8'd0, 32'd5,           8'd0, 32'd0,           8'd0};
`else
        tbl[9] = '{1'b0, 8'd2, 32'd9,  32'd0,  32'd0, 8'd1, DIV, 4'd0, 16'd6,  1'b0, 8'd1, 32'hFFFF_FFFF,   8'd1, 32'hFFFF_FFFF,   8'd0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu", al_A | al_B | {28'd0, al_cmd}, 32'd0);
        chk("rst_strobes", {29'd0, dt_pop, dt_push, op_pop}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Count saturation: 257 ones reduced by 256 ADDs.
        @(negedge clk);
        for (int i = 0; i < 257; i++) ld_dmem[i] = 32'd1;
        for (int i = 0; i < 256; i++) ld_omem[i] = ADD;
        ld_dsp = 257;
        ld_osp = 256;
        ld     = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        run(1'b1, 2000, dcyc, derr);
        chk("sat_cycle", dcyc, 32'd1282);
        chk("sat_err", {31'd0, derr}, 32'd0);
        chk("sat_count", {24'd0, count}, 32'd255);
        chk("sat_result", result, 32'd257);
        chk("sat_dsp", dsp, 32'd1);

        // Reset asserted during EXEC, between clock edges.
        @(negedge clk);
        ld_dmem[0] = 32'd7;
        ld_dmem[1] = 32'd3;
        ld_omem[0] = SUB;
        ld_dsp     = 2;
        ld_osp     = 1;
        ld         = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        start = 1'b1;
        drain = 1'b0;
        @(posedge clk);
        repeat (4) @(negedge clk);
        start = 1'b0;
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_alu_cmd", {28'd0, al_cmd}, {28'd0, SUB});
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_strobes", {29'd0, dt_pop, dt_push, op_pop}, 32'd0);
        chk("mid_rst_alu", al_A | al_B | {28'd0, al_cmd}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_dsp", dsp, 32'd0);
        do_vec("after_rst", tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
